// File: rtl/midi_message_sender.sv
// MIDI OUT transmitter: accepts one channel-voice message per valid/ready
// handshake, optionally elides a repeated status byte (running status) and
// shifts the resulting 1-3 byte sequence out as 8N1 UART frames on MIDI_TX.
module midi_message_sender #(
   parameter int unsigned CLK_FREQ_HZ    = 25000000,
   parameter int unsigned BAUD           = 31250,
   parameter int unsigned RUNNING_STATUS = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       msg_valid,
   output logic       msg_ready,
   input  logic [3:0] msg_status,
   input  logic [3:0] msg_channel,
   input  logic [6:0] msg_data0,
   input  logic [6:0] msg_data1,
   output logic       MIDI_TX,
   output logic       msg_done,
   output logic       msg_error
);

   localparam int unsigned BIT_TICKS = CLK_FREQ_HZ / BAUD;
   localparam int unsigned TickW     = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
   localparam logic [TickW-1:0] TickMax = TickW'(BIT_TICKS - 1);

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StData,
      StStop
   } state_e;

   // Control and datapath state
   state_e           state_q, state_d;
   logic [TickW-1:0] tick_q, tick_d;
   logic [2:0]       bit_q, bit_d;
   logic [1:0]       byte_idx_q, byte_idx_d;
   logic [1:0]       last_idx_q, last_idx_d;
   logic [2:0][7:0]  frame_q, frame_d;
   logic [7:0]       last_status_q, last_status_d;

   // Registered outputs
   logic tx_q, tx_d;
   logic ready_q, ready_d;
   logic done_q, done_d;
   logic error_q, error_d;

   // Decoded conditions
   logic       tick_end;
   logic       last_stop_end;
   logic       can_accept;
   logic       accept;
   logic       msg_supported;
   logic       msg_two_data;
   logic       skip_status;
   logic [7:0] status_byte;
   logic [7:0] data0_byte;
   logic [7:0] data1_byte;

   assign tick_end      = (tick_q == TickMax);
   assign last_stop_end = (state_q == StStop) && tick_end && (byte_idx_q == last_idx_q);
   // The edge that completes the final stop bit also serves as an acceptance
   // edge, so a waiting message starts with no idle gap on the line.
   assign can_accept    = (state_q == StIdle) || last_stop_end;
   assign accept        = msg_valid && can_accept;
   assign msg_supported = msg_status[3] && (msg_status != 4'hF);
   assign msg_two_data  = (msg_status != 4'hC) && (msg_status != 4'hD);
   assign status_byte   = {msg_status, msg_channel};
   assign data0_byte    = {1'b0, msg_data0};
   assign data1_byte    = {1'b0, msg_data1};
   // last_status_q resets to 0x00, which never matches a real status byte
   assign skip_status   = (RUNNING_STATUS != 0) && (status_byte == last_status_q);

   // State register: control, counters, captured frame bytes and last status
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         tick_q        <= '0;
         bit_q         <= '0;
         byte_idx_q    <= '0;
         last_idx_q    <= '0;
         frame_q       <= '0;
         last_status_q <= 8'h00;
      end else begin
         state_q       <= state_d;
         tick_q        <= tick_d;
         bit_q         <= bit_d;
         byte_idx_q    <= byte_idx_d;
         last_idx_q    <= last_idx_d;
         frame_q       <= frame_d;
         last_status_q <= last_status_d;
      end
   end

   // Next-state logic: bit timing, frame sequencing and message capture
   always_comb begin
      state_d       = state_q;
      tick_d        = tick_q;
      bit_d         = bit_q;
      byte_idx_d    = byte_idx_q;
      last_idx_d    = last_idx_q;
      frame_d       = frame_q;
      last_status_d = last_status_q;

      unique case (state_q)
         StIdle: begin
            tick_d = '0;
         end
         StStart: begin
            if (tick_end) begin
               tick_d  = '0;
               bit_d   = 3'd0;
               state_d = StData;
            end else begin
               tick_d = tick_q + TickW'(1);
            end
         end
         StData: begin
            if (tick_end) begin
               tick_d = '0;
               if (bit_q == 3'd7) begin
                  state_d = StStop;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               tick_d = tick_q + TickW'(1);
            end
         end
         StStop: begin
            if (tick_end) begin
               tick_d = '0;
               if (byte_idx_q == last_idx_q) begin
                  state_d = StIdle;
               end else begin
                  byte_idx_d = byte_idx_q + 2'd1;
                  state_d    = StStart;
               end
            end else begin
               tick_d = tick_q + TickW'(1);
            end
         end
      endcase

      // Unsupported messages are consumed without touching any state
      if (accept && msg_supported) begin
         state_d    = StStart;
         tick_d     = '0;
         bit_d      = 3'd0;
         byte_idx_d = 2'd0;
         if (skip_status) begin
            frame_d[0] = data0_byte;
            frame_d[1] = data1_byte;
            frame_d[2] = 8'h00;
            last_idx_d = msg_two_data ? 2'd1 : 2'd0;
         end else begin
            frame_d[0]    = status_byte;
            frame_d[1]    = data0_byte;
            frame_d[2]    = data1_byte;
            last_idx_d    = msg_two_data ? 2'd2 : 2'd1;
            last_status_d = status_byte;
         end
      end
   end

   // Output logic: outputs are precomputed from the next state and registered
   always_comb begin
      tx_d = 1'b1;
      unique case (state_d)
         StIdle:  tx_d = 1'b1;
         StStart: tx_d = 1'b0;
         StData:  tx_d = frame_d[byte_idx_d][bit_d];
         StStop:  tx_d = 1'b1;
      endcase
      ready_d = (state_d == StIdle);
      done_d  = last_stop_end;
      error_d = accept && !msg_supported;
   end

   // Output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_q    <= 1'b1;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         tx_q    <= tx_d;
         ready_q <= ready_d;
         done_q  <= done_d;
         error_q <= error_d;
      end
   end

   assign MIDI_TX   = tx_q;
   assign msg_ready = ready_q;
   assign msg_done  = done_q;
   assign msg_error = error_q;

endmodule

// File: tb/tb_midi_message_sender.sv
// Self-checking bench for midi_message_sender: a queue-based waveform model
// predicts every output each cycle, a UART decoder recovers bytes from
// MIDI_TX, and directed scenarios pin literal byte sequences and timing.
module tb_midi_message_sender;

   localparam int unsigned ClkHz = 312500;
   localparam int unsigned Baud  = 31250;
   localparam int unsigned BT    = ClkHz / Baud;
   localparam bit          RS    = 1'b1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       msg_valid = 1'b0;
   logic       msg_ready;
   logic [3:0] msg_status = 4'h0;
   logic [3:0] msg_channel = 4'h0;
   logic [6:0] msg_data0 = 7'h00;
   logic [6:0] msg_data1 = 7'h00;
   logic       MIDI_TX;
   logic       msg_done;
   logic       msg_error;

   midi_message_sender #(
      .CLK_FREQ_HZ   (ClkHz),
      .BAUD          (Baud),
      .RUNNING_STATUS(32'(RS))
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .msg_valid  (msg_valid),
      .msg_ready  (msg_ready),
      .msg_status (msg_status),
      .msg_channel(msg_channel),
      .msg_data0  (msg_data0),
      .msg_data1  (msg_data1),
      .MIDI_TX    (MIDI_TX),
      .msg_done   (msg_done),
      .msg_error  (msg_error)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // mdl_q holds the expected MIDI_TX level for every future cycle of the
   // transmission in flight; empty means idle.
   logic       mdl_q[$];
   logic [7:0] exp_bytes[$];
   logic [7:0] mdl_last = 8'h00;
   int         cyc = 0;
   int         acc_cyc = -1;
   logic       exp_tx = 1'b1, exp_ready = 1'b1, exp_done = 1'b0, exp_err = 1'b0;

   function automatic void push_frame(input logic [7:0] b);
      for (int k = 0; k < 10; k++) begin
         logic v;
         v = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
         for (int t = 0; t < int'(BT); t++) mdl_q.push_back(v);
      end
      exp_bytes.push_back(b);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      logic [7:0] sb;
      if (!rst_n) begin
         mdl_q.delete();
         exp_bytes.delete();
         mdl_last  = 8'h00;
         exp_tx    = 1'b1;
         exp_ready = 1'b1;
         exp_done  = 1'b0;
         exp_err   = 1'b0;
      end else begin
         cyc++;
         exp_done = 1'b0;
         exp_err  = 1'b0;
         if (mdl_q.size() > 0) begin
            void'(mdl_q.pop_front());
            if (mdl_q.size() == 0) exp_done = 1'b1;
         end
         if (msg_valid && mdl_q.size() == 0) begin
            acc_cyc = cyc;
            if (msg_status >= 4'h8 && msg_status != 4'hF) begin
               sb = {msg_status, msg_channel};
               if (!(RS && sb == mdl_last)) begin
                  push_frame(sb);
                  mdl_last = sb;
               end
               push_frame({1'b0, msg_data0});
               if (msg_status != 4'hC && msg_status != 4'hD) push_frame({1'b0, msg_data1});
            end else begin
               exp_err = 1'b1;
            end
         end
         exp_tx    = (mdl_q.size() > 0) ? mdl_q[0] : 1'b1;
         exp_ready = (mdl_q.size() == 0);
      end
   end

   // ---------------- per-cycle compare ----------------
   int ready_low_cnt = 0, done_cnt = 0, err_cnt = 0, tx_low_cnt = 0;
   int done_cyc = -1;

   always @(negedge clk) begin
      chk("MIDI_TX", MIDI_TX, exp_tx);
      chk("msg_ready", msg_ready, exp_ready);
      chk("msg_done", msg_done, exp_done);
      chk("msg_error", msg_error, exp_err);
      if (rst_n === 1'b1) begin
         if (msg_ready === 1'b0) ready_low_cnt++;
         if (msg_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (msg_error === 1'b1) err_cnt++;
         if (MIDI_TX === 1'b0) tx_low_cnt++;
      end
   end

   // ---------------- UART decoder ----------------
   logic [7:0] rx_log[$];
   bit         rx_busy = 1'b0;
   int         rx_cnt = 0;
   logic [7:0] rx_sh = 8'h00;

   always @(negedge clk) begin
      int k;
      if (rst_n !== 1'b1) begin
         rx_busy = 1'b0;
      end else if (!rx_busy) begin
         if (MIDI_TX === 1'b0) begin
            rx_busy = 1'b1;
            rx_cnt  = 0;
         end
      end else begin
         rx_cnt++;
         if (rx_cnt % int'(BT) == int'(BT) / 2) begin
            k = rx_cnt / int'(BT);
            if (k == 0) begin
               chk("start_bit", MIDI_TX, 1'b0);
            end else if (k <= 8) begin
               rx_sh[k-1] = MIDI_TX;
            end else begin
               chk("stop_bit", MIDI_TX, 1'b1);
               rx_log.push_back(rx_sh);
               if (exp_bytes.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL rx_byte: got 0x%0h, expected no byte", rx_sh);
               end else begin
                  chk("rx_byte", rx_sh, exp_bytes.pop_front());
               end
               rx_busy = 1'b0;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic [3:0] st, input logic [3:0] ch, input logic [6:0] d0,
                       input logic [6:0] d1, input bit release_valid);
      int n;
      n = 0;
      @(negedge clk);
      msg_valid   = 1'b1;
      msg_status  = st;
      msg_channel = ch;
      msg_data0   = d0;
      msg_data1   = d1;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (acc_cyc != cyc && n < 4000);
      if (acc_cyc != cyc) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: got no acceptance, expected one within 4000 cycles");
      end
      if (release_valid) begin
         @(negedge clk);
         msg_valid = 1'b0;
      end
   endtask

   task automatic wait_done(input int target, output int when);
      int n;
      n = 0;
      while (done_cnt < target && n < 4000) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (done_cnt < target) begin
         n_checks++;
         n_fail++;
         $display("FAIL done_timeout: got %0d done pulses, expected %0d", done_cnt, target);
         when = -1;
      end else begin
         when = done_cyc;
      end
   endtask

   task automatic chk_rx(input string name, input int off, input logic [7:0] b0,
                         input logic [7:0] b1, input logic [7:0] b2, input int n);
      logic [7:0] e[3];
      e[0] = b0;
      e[1] = b1;
      e[2] = b2;
      for (int k = 0; k < n; k++) begin
         chk(name, (off + k < rx_log.size()) ? rx_log[off+k] : 8'hXX, e[k]);
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int a, a2, w, base, n;
      logic [3:0] st, ch;
      bit rel;

      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_tx", MIDI_TX, 1'b1);
      chk("reset_ready", msg_ready, 1'b1);
      chk("reset_done", msg_done, 1'b0);
      chk("reset_error", msg_error, 1'b0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // NoteOn ch0 note 60 vel 100
      rx_log.delete();
      ready_low_cnt = 0;
      base = done_cnt;
      send(4'h9, 4'h0, 7'd60, 7'd100, 1'b1);
      a = acc_cyc;
      chk("model_frame_len", mdl_q.size(), 3 * 10 * BT);
      chk("model_first_byte", exp_bytes[0], 8'h90);
      wait_done(base + 1, w);
      chk("noteon_latency", w - a, 300);
      repeat (2) @(negedge clk);
      chk("noteon_ready_low", ready_low_cnt, 300);
      chk("noteon_count", rx_log.size(), 3);
      chk_rx("noteon_bytes", 0, 8'h90, 8'h3C, 8'h64, 3);

      // Running status: same status, sent immediately after done
      rx_log.delete();
      base = done_cnt;
      send(4'h9, 4'h0, 7'd62, 7'd80, 1'b1);
      a = acc_cyc;
      wait_done(base + 1, w);
      chk("running_latency", w - a, 200);
      chk("running_count", rx_log.size(), 2);
      chk_rx("running_bytes", 0, 8'h3E, 8'h50, 8'h00, 2);

      // Program change then CC on ch5: status resent because it changed
      rx_log.delete();
      base = done_cnt;
      send(4'hC, 4'h5, 7'h7F, 7'h11, 1'b1);
      a = acc_cyc;
      wait_done(base + 1, w);
      chk("program_latency", w - a, 200);
      send(4'hB, 4'h5, 7'h01, 7'h40, 1'b1);
      a = acc_cyc;
      wait_done(base + 2, w);
      chk("cc_latency", w - a, 300);
      chk("prog_cc_count", rx_log.size(), 5);
      chk_rx("prog_bytes", 0, 8'hC5, 8'h7F, 8'h00, 2);
      chk_rx("cc_bytes", 2, 8'hB5, 8'h01, 8'h40, 3);

      // Unsupported status is dropped with an error pulse
      rx_log.delete();
      repeat (2) @(negedge clk);
      ready_low_cnt = 0;
      err_cnt       = 0;
      tx_low_cnt    = 0;
      send(4'h3, 4'h0, 7'h12, 7'h34, 1'b1);
      repeat (5) @(negedge clk);
      chk("drop_error_pulses", err_cnt, 1);
      chk("drop_ready_low", ready_low_cnt, 0);
      chk("drop_tx_low", tx_low_cnt, 0);
      chk("drop_rx_count", rx_log.size(), 0);
      base = done_cnt;
      send(4'h9, 4'h0, 7'h30, 7'h10, 1'b1);
      wait_done(base + 1, w);
      chk("after_drop_count", rx_log.size(), 3);
      chk_rx("after_drop_bytes", 0, 8'h90, 8'h30, 8'h10, 3);

      // Pitch bend with valid held: next message taken on the done edge
      rx_log.delete();
      base = done_cnt;
      send(4'hE, 4'hF, 7'h00, 7'h40, 1'b0);
      a = acc_cyc;
      send(4'hB, 4'hF, 7'h07, 7'h22, 1'b1);
      a2 = acc_cyc;
      chk("b2b_accept_edge", a2 - a, 300);
      wait_done(base + 2, w);
      chk("b2b_second_latency", w - a2, 300);
      chk("b2b_count", rx_log.size(), 6);
      chk_rx("pitchbend_bytes", 0, 8'hEF, 8'h00, 8'h40, 3);
      chk_rx("b2b_cc_bytes", 3, 8'hBF, 8'h07, 8'h22, 3);

      // Reset during the 5th data bit of the second byte
      rx_log.delete();
      send(4'h9, 4'h3, 7'h40, 7'h55, 1'b1);
      repeat (15 * BT + 3) @(posedge clk);
      #2;
      chk("tx_before_reset", MIDI_TX, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("async_reset_tx", MIDI_TX, 1'b1);
      chk("async_reset_ready", msg_ready, 1'b1);
      base = done_cnt;
      repeat (3) @(negedge clk);
      #1;
      rst_n = 1'b1;
      repeat (30 * BT) @(negedge clk);
      chk("reset_no_done", done_cnt, base);
      chk("reset_partial_rx", rx_log.size(), 1);
      rx_log.delete();
      send(4'h9, 4'h3, 7'h40, 7'h55, 1'b1);
      wait_done(base + 1, w);
      chk("post_reset_count", rx_log.size(), 3);
      chk_rx("post_reset_bytes", 0, 8'h93, 8'h40, 8'h55, 3);

      // Randomized messages against the model
      for (int i = 0; i < 40; i++) begin
         st = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) != 0) st = 4'($urandom_range(8, 14));
         ch  = 4'($urandom_range(0, 1));
         rel = ($urandom_range(0, 2) != 0) || (i == 39);
         send(st, ch, 7'($urandom), 7'($urandom), rel);
         if (rel) repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      n = 0;
      while (mdl_q.size() != 0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      repeat (5) @(negedge clk);
      chk("random_all_bytes_seen", exp_bytes.size(), 0);
      chk("random_idle_ready", msg_ready, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: got no end of test, expected completion before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
